db_multi_edge: RTL and testbench

//   Parametrised multi-channel switch/sensor debouncer with edge pulses.

---
 rtl/db_multi_edge_if.sv | 29 ++
 rtl/db_multi_edge.sv | 144 ++++++++++++++
 tb/tb_db_multi_edge.sv | 326 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/db_multi_edge_if.sv
// Pin-side bundle of the multi-channel debouncer: raw switch/sensor inputs in,
// debounced levels, edge pulses and the prescaler tick out.
interface db_multi_edge_if #(
  parameter int CH = 4
);
  logic [CH-1:0] sw;
  logic [CH-1:0] db;
  logic [CH-1:0] rise;
  logic [CH-1:0] fall;
  logic          tick;

  // Driver side: the pins / stimulus that feeds raw inputs and watches results.
  modport master (
    output sw,
    input  db,
    input  rise,
    input  fall,
    input  tick
  );

  // Debouncer side.
  modport slave (
    input  sw,
    output db,
    output rise,
    output fall,
    output tick
  );
endinterface

// File: rtl/db_multi_edge.sv
// Multi-channel switch/sensor debouncer. Each raw input is synchronised, then
// filtered by its own two-state FSM that requires the input to disagree with
// the debounced level for STABLE_TICKS consecutive prescaler ticks before the
// level flips. A flip is accompanied by a registered one-cycle rise or fall
// pulse so downstream counters can consume edges directly.
module db_multi_edge #(
  parameter int CH           = 4,
  parameter int TICK_DIV     = 500000,
  parameter int STABLE_TICKS = 3
) (
  input logic            clk,
  input logic            reset,
  db_multi_edge_if.slave bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = (STABLE_TICKS > 0) ? $clog2(STABLE_TICKS + 1) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_TICKS - 1);

  typedef enum logic {
    ST_STABLE  = 1'b0,
    ST_PENDING = 1'b1
  } state_t;

  // Synchroniser stages: sync_p1 is the metastability-safe view of sw.
  logic [CH-1:0] sync_p0;
  logic [CH-1:0] sync_p1;

  // Shared sample-rate prescaler.
  logic [PW-1:0] pre_cnt;
  logic          tick;

  // Per-channel filter state.
  state_t        state_q [CH];
  state_t        state_d [CH];
  logic [CW-1:0] cnt_q   [CH];
  logic [CW-1:0] cnt_d   [CH];
  logic [CH-1:0] db_q;
  logic [CH-1:0] db_d;
  logic [CH-1:0] rise_q;
  logic [CH-1:0] rise_d;
  logic [CH-1:0] fall_q;
  logic [CH-1:0] fall_d;

  // ---- stage p0/p1: two-flop synchroniser per channel ----
  // Bring the asynchronous raw pins into the clk domain.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_p0 <= '0;
      sync_p1 <= '0;
    end else begin
      sync_p0 <= bus.sw;
      sync_p1 <= sync_p0;
    end
  end

  // Free-running prescaler, wraps after TICK_DIV cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pre_cnt <= '0;
    end else if (pre_cnt == PRE_LAST) begin
      pre_cnt <= '0;
    end else begin
      pre_cnt <= pre_cnt + PW'(1);
    end
  end

  // The tick is a decode of the prescaler register, so it is glitch-free and
  // lands in the last cycle of each sample period.
  assign tick = (pre_cnt == PRE_LAST);

  // ---- stage p2: per-channel debounce FSM, level and edge registers ----
  // Filter state, debounced level and edge pulses all update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= ST_STABLE;
        cnt_q[i]   <= '0;
      end
      db_q   <= '0;
      rise_q <= '0;
      fall_q <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        state_q[i] <= state_d[i];
        cnt_q[i]   <= cnt_d[i];
      end
      db_q   <= db_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end

  // Next-state logic. An abort (input back to the debounced level) wins over
  // a tick in the same cycle, and the tick coinciding with entry into PENDING
  // is deliberately ignored so every attempt sees full sample periods.
  always_comb begin
    for (int i = 0; i < CH; i++) begin
      state_d[i] = state_q[i];
      cnt_d[i]   = cnt_q[i];
    end
    db_d   = db_q;
    rise_d = '0;
    fall_d = '0;

    for (int i = 0; i < CH; i++) begin
      unique case (state_q[i])
        ST_STABLE: begin
          if (sync_p1[i] != db_q[i]) begin
            state_d[i] = ST_PENDING;
            cnt_d[i]   = '0;
          end
        end
        ST_PENDING: begin
          if (sync_p1[i] == db_q[i]) begin
            state_d[i] = ST_STABLE;
            cnt_d[i]   = '0;
          end else if (tick) begin
            if (cnt_q[i] == CNT_LAST) begin
              state_d[i] = ST_STABLE;
              cnt_d[i]   = '0;
              db_d[i]    = sync_p1[i];
              rise_d[i]  = sync_p1[i];
              fall_d[i]  = ~sync_p1[i];
            end else begin
              cnt_d[i] = cnt_q[i] + CW'(1);
            end
          end
        end
        default: begin
          state_d[i] = ST_STABLE;
          cnt_d[i]   = '0;
        end
      endcase
    end
  end

  assign bus.db   = db_q;
  assign bus.rise = rise_q;
  assign bus.fall = fall_q;
  assign bus.tick = tick;

endmodule

// File: tb/tb_db_multi_edge.sv
// Bench for db_multi_edge with CH=2, TICK_DIV=4, STABLE_TICKS=3.
// Expected level flips are queued when stimulus is applied and checked against
// the observed pulse timing once the observation window closes.
module tb_db_multi_edge;

  localparam int CH       = 2;
  localparam int TICK_DIV = 4;
  localparam int STABLE   = 3;
  localparam int LAT_LO   = 3 + (STABLE - 1) * TICK_DIV + 1;
  localparam int LAT_HI   = 3 + STABLE * TICK_DIV;

  logic clk;
  logic reset;

  db_multi_edge_if #(.CH(CH)) bus ();

  db_multi_edge #(
    .CH          (CH),
    .TICK_DIV    (TICK_DIV),
    .STABLE_TICKS(STABLE)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int ch;
    bit is_rise;
    int lo;
    int hi;
  } exp_t;

  exp_t sb[$];

  int n_cmp;
  int n_bad;

  // Observation results, edges numbered from 1 relative to the window start.
  int rise_edge [CH];
  int fall_edge [CH];
  int rise_cnt  [CH];
  int fall_cnt  [CH];
  int db_edge   [CH];
  int db_chg    [CH];
  int both_hi;
  int nz_out;
  int tick_cnt;
  int first_tick;
  int tick_gap_err;

  // Record what the outputs do over n clock edges (sampled on the falling edge).
  task automatic observe(input int n);
    logic [CH-1:0] db_prev;
    int last_tick;
    db_prev = bus.db;
    last_tick = -1;
    for (int c = 0; c < CH; c++) begin
      rise_edge[c] = -1; fall_edge[c] = -1; db_edge[c] = -1;
      rise_cnt[c] = 0; fall_cnt[c] = 0; db_chg[c] = 0;
    end
    both_hi = 0; nz_out = 0; tick_cnt = 0; first_tick = -1; tick_gap_err = 0;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < CH; c++) begin
        if (bus.rise[c] === 1'b1) begin
          rise_cnt[c]++;
          if (rise_edge[c] < 0) rise_edge[c] = k;
        end
        if (bus.fall[c] === 1'b1) begin
          fall_cnt[c]++;
          if (fall_edge[c] < 0) fall_edge[c] = k;
        end
        if (bus.rise[c] === 1'b1 && bus.fall[c] === 1'b1) both_hi++;
        if (bus.db[c] !== db_prev[c]) begin
          db_chg[c]++;
          if (db_edge[c] < 0) db_edge[c] = k;
        end
      end
      if (bus.db !== '0 || bus.rise !== '0 || bus.fall !== '0) nz_out++;
      if (bus.tick === 1'b1) begin
        tick_cnt++;
        if (first_tick < 0) first_tick = k;
        if (last_tick >= 0 && k - last_tick != TICK_DIV) tick_gap_err++;
        last_tick = k;
      end
      db_prev = bus.db;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.sw = '0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.db !== 2'b00 || bus.rise !== 2'b00 || bus.fall !== 2'b00 || bus.tick !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_outputs: db=%b rise=%b fall=%b tick=%b, want all 0",
               bus.db, bus.rise, bus.fall, bus.tick);
    end
  endtask

  task automatic test_idle();
    reset = 1'b0;
    observe(100);
    n_cmp++;
    if (nz_out !== 0) begin
      n_bad++;
      $display("FAIL idle_quiet: %0d cycles with db/rise/fall nonzero, want 0", nz_out);
    end
    n_cmp++;
    if (tick_cnt !== 25 || first_tick !== 3 || tick_gap_err !== 0) begin
      n_bad++;
      $display("FAIL idle_tick: count=%0d first=%0d gap_err=%0d, want 25/3/0",
               tick_cnt, first_tick, tick_gap_err);
    end
  endtask

  task automatic test_rise_ch0();
    exp_t e;
    int got;
    bus.sw[0] = 1'b1;
    sb.push_back('{ch: 0, is_rise: 1'b1, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi) begin
        n_bad++;
        $display("FAIL rise_ch0_latency: ch%0d edge %0d, want %0d..%0d", e.ch, got, e.lo, e.hi);
      end
      n_cmp++;
      if (rise_cnt[e.ch] !== 1 || db_edge[e.ch] !== got || db_chg[e.ch] !== 1) begin
        n_bad++;
        $display("FAIL rise_ch0_pulse: pulses=%0d db_edge=%0d db_chg=%0d, want 1/%0d/1",
                 rise_cnt[e.ch], db_edge[e.ch], db_chg[e.ch], got);
      end
    end
    n_cmp++;
    if (bus.db !== 2'b01 || db_chg[1] !== 0 || rise_cnt[1] !== 0 || fall_cnt[1] !== 0 || fall_cnt[0] !== 0) begin
      n_bad++;
      $display("FAIL rise_ch0_isolation: db=%b ch1 chg=%0d r=%0d f=%0d ch0 f=%0d, want 01/0/0/0/0",
               bus.db, db_chg[1], rise_cnt[1], fall_cnt[1], fall_cnt[0]);
    end
  endtask

  task automatic test_glitch_ch1();
    exp_t e;
    int got;
    bus.sw[1] = 1'b1;
    fork
      observe(30);
      begin
        repeat (6) @(negedge clk);
        bus.sw[1] = 1'b0;
      end
    join
    n_cmp++;
    if (db_chg[1] !== 0 || rise_cnt[1] !== 0 || fall_cnt[1] !== 0 || bus.db !== 2'b01) begin
      n_bad++;
      $display("FAIL glitch_reject: ch1 chg=%0d rise=%0d fall=%0d db=%b, want 0/0/0/01",
               db_chg[1], rise_cnt[1], fall_cnt[1], bus.db);
    end
    // A genuine press afterwards still needs the full debounce time.
    bus.sw[1] = 1'b1;
    sb.push_back('{ch: 1, is_rise: 1'b1, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi || rise_cnt[e.ch] !== 1 || db_edge[e.ch] !== got) begin
        n_bad++;
        $display("FAIL glitch_then_hold: ch%0d rise edge %0d pulses %0d db_edge %0d, want %0d..%0d/1/same",
                 e.ch, got, rise_cnt[e.ch], db_edge[e.ch], e.lo, e.hi);
      end
    end
    bus.sw[1] = 1'b0;
    sb.push_back('{ch: 1, is_rise: 1'b0, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi || fall_cnt[e.ch] !== 1 || rise_cnt[e.ch] !== 0) begin
        n_bad++;
        $display("FAIL ch1_release: fall edge %0d pulses %0d rise %0d, want %0d..%0d/1/0",
                 got, fall_cnt[e.ch], rise_cnt[e.ch], e.lo, e.hi);
      end
    end
  endtask

  task automatic test_fall_ch0();
    exp_t e;
    int got;
    bus.sw[0] = 1'b0;
    sb.push_back('{ch: 0, is_rise: 1'b0, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi) begin
        n_bad++;
        $display("FAIL fall_ch0_latency: edge %0d, want %0d..%0d", got, e.lo, e.hi);
      end
      n_cmp++;
      if (fall_cnt[0] !== 1 || rise_cnt[0] !== 0 || db_edge[0] !== got || both_hi !== 0) begin
        n_bad++;
        $display("FAIL fall_ch0_pulse: fall=%0d rise=%0d db_edge=%0d both=%0d, want 1/0/%0d/0",
                 fall_cnt[0], rise_cnt[0], db_edge[0], both_hi, got);
      end
    end
    n_cmp++;
    if (bus.db !== 2'b00) begin
      n_bad++;
      $display("FAIL fall_ch0_level: db=%b, want 00", bus.db);
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int got;
    bus.sw = 2'b11;
    sb.push_back('{ch: 0, is_rise: 1'b1, lo: LAT_LO, hi: LAT_HI});
    sb.push_back('{ch: 1, is_rise: 1'b1, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi || rise_cnt[e.ch] !== 1 || db_edge[e.ch] !== got) begin
        n_bad++;
        $display("FAIL both_rise_ch%0d: edge %0d pulses %0d db_edge %0d, want %0d..%0d/1/same",
                 e.ch, got, rise_cnt[e.ch], db_edge[e.ch], e.lo, e.hi);
      end
    end
    n_cmp++;
    if (rise_edge[0] !== rise_edge[1] || bus.db !== 2'b11) begin
      n_bad++;
      $display("FAIL both_rise_same_cycle: edges %0d/%0d db=%b, want equal and 11",
               rise_edge[0], rise_edge[1], bus.db);
    end
    bus.sw = 2'b00;
    sb.push_back('{ch: 0, is_rise: 1'b0, lo: LAT_LO, hi: LAT_HI});
    sb.push_back('{ch: 1, is_rise: 1'b0, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi || fall_cnt[e.ch] !== 1 || rise_cnt[e.ch] !== 0) begin
        n_bad++;
        $display("FAIL both_fall_ch%0d: edge %0d falls %0d rises %0d, want %0d..%0d/1/0",
                 e.ch, got, fall_cnt[e.ch], rise_cnt[e.ch], e.lo, e.hi);
      end
    end
  endtask

  task automatic test_reset_pending();
    exp_t e;
    int got;
    int bad_rst;
    bus.sw[0] = 1'b1;
    observe(8);
    n_cmp++;
    if (db_chg[0] !== 0 || rise_cnt[0] !== 0) begin
      n_bad++;
      $display("FAIL pre_reset_pending: db_chg=%0d rise=%0d, want 0/0", db_chg[0], rise_cnt[0]);
    end
    // Assert reset away from any clock edge to exercise the asynchronous path.
    #2 reset = 1'b1;
    #1;
    bad_rst = 0;
    if (bus.db !== 2'b00 || bus.rise !== 2'b00 || bus.fall !== 2'b00) bad_rst++;
    repeat (3) begin
      @(negedge clk);
      if (bus.db !== 2'b00 || bus.rise !== 2'b00 || bus.fall !== 2'b00) bad_rst++;
    end
    n_cmp++;
    if (bad_rst !== 0) begin
      n_bad++;
      $display("FAIL reset_mid_pending: %0d samples with nonzero outputs, want 0", bad_rst);
    end
    reset = 1'b0;
    sb.push_back('{ch: 0, is_rise: 1'b1, lo: LAT_LO, hi: LAT_HI});
    observe(20);
    while (sb.size() > 0) begin
      e = sb.pop_front();
      got = e.is_rise ? rise_edge[e.ch] : fall_edge[e.ch];
      n_cmp++;
      if (got < e.lo || got > e.hi || rise_cnt[e.ch] !== 1 || db_edge[e.ch] !== got) begin
        n_bad++;
        $display("FAIL post_reset_rise: edge %0d pulses %0d db_edge %0d, want %0d..%0d/1/same",
                 got, rise_cnt[e.ch], db_edge[e.ch], e.lo, e.hi);
      end
    end
    n_cmp++;
    if (bus.db !== 2'b01) begin
      n_bad++;
      $display("FAIL post_reset_level: db=%b, want 01", bus.db);
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    reset = 1'b1;
    bus.sw = '0;
    test_reset();
    test_idle();
    test_rise_ch0();
    test_glitch_ch1();
    test_fall_ch0();
    test_back_to_back();
    test_reset_pending();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
